// File: rtl/matrix_mult_scheduler_if.sv
// Operand-read and result-write bus between the matrix multiply scheduler
// and its external A, B and C memories.
interface matrix_mult_scheduler_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8
);
    logic                  o_rd_en;
    logic [ADDR_WIDTH-1:0] o_a_addr;
    logic [ADDR_WIDTH-1:0] o_b_addr;
    logic [DATA_WIDTH-1:0] i_a_data;
    logic [DATA_WIDTH-1:0] i_b_data;
    logic                  o_wr_en;
    logic [ADDR_WIDTH-1:0] o_wr_addr;
    logic [DATA_WIDTH-1:0] o_wr_data;

    modport master (
        output o_rd_en, o_a_addr, o_b_addr, o_wr_en, o_wr_addr, o_wr_data,
        input  i_a_data, i_b_data
    );

    modport slave (
        input  o_rd_en, o_a_addr, o_b_addr, o_wr_en, o_wr_addr, o_wr_data,
        output i_a_data, i_b_data
    );
endinterface

// File: rtl/matrix_mult_scheduler.sv
// Walks the (i, j, k) index space of C = A x B through one shared MAC,
// issuing operand reads and writing each finished C element in row-major order.
//
// state | meaning
// IDLE  | waiting for i_start
// ISSUE | one operand read per cycle for the current (i, j, k)
// DRAIN | last product of the element lands in the accumulator
// WRITE | C[i][j] written, indices advance
// DONE  | one-cycle completion pulse
module matrix_mult_scheduler #(
    parameter int FIRST_MATRIX_HEIGHT = 5,
    parameter int BOTH_MATRIX_W_H     = 5,
    parameter int SECOND_MATRIX_WIDTH = 5,
    parameter int DATA_WIDTH          = 8,
    parameter int ADDR_WIDTH          = 8
) (
    input  logic clk,
    input  logic i_rst,
    input  logic i_start,
    output logic o_busy,
    output logic o_done,
    matrix_mult_scheduler_if.master mem
);
    localparam int H     = FIRST_MATRIX_HEIGHT;
    localparam int K     = BOTH_MATRIX_W_H;
    localparam int W     = SECOND_MATRIX_WIDTH;
    localparam int IW    = (H > 1) ? $clog2(H) : 1;
    localparam int KW    = (K > 1) ? $clog2(K) : 1;
    localparam int JW    = (W > 1) ? $clog2(W) : 1;
    localparam int ACC_W = 2 * DATA_WIDTH + $clog2(K);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] ISSUE = 3'd1;
    localparam logic [2:0] DRAIN = 3'd2;
    localparam logic [2:0] WRITE = 3'd3;
    localparam logic [2:0] DONE  = 3'd4;

    logic [2:0]              state;
    logic [IW-1:0]           i;
    logic [JW-1:0]           j;
    logic [KW-1:0]           k;
    logic [ACC_W-1:0]        acc;
    logic                    rd_en_d;
    logic                    first_d;
    logic [2*DATA_WIDTH-1:0] prod;
    logic                    rd_en;
    logic                    wr_en;
    logic                    unused_acc_hi;

    assign prod  = mem.i_a_data * mem.i_b_data;
    assign rd_en = (state == ISSUE);
    assign wr_en = (state == WRITE);

    // Strobe-gated outputs: addresses and data read as zero when idle.
    assign o_busy        = rd_en || (state == DRAIN) || wr_en;
    assign o_done        = (state == DONE);
    assign mem.o_rd_en   = rd_en;
    assign mem.o_a_addr  = rd_en ? ADDR_WIDTH'(i) * ADDR_WIDTH'(K) + ADDR_WIDTH'(k) : '0;
    assign mem.o_b_addr  = rd_en ? ADDR_WIDTH'(k) * ADDR_WIDTH'(W) + ADDR_WIDTH'(j) : '0;
    assign mem.o_wr_en   = wr_en;
    assign mem.o_wr_addr = wr_en ? ADDR_WIDTH'(i) * ADDR_WIDTH'(W) + ADDR_WIDTH'(j) : '0;
    assign mem.o_wr_data = wr_en ? acc[DATA_WIDTH-1:0] : '0;

    // Only the low DATA_WIDTH bits leave the block; the result wraps modulo 2^DATA_WIDTH.
    assign unused_acc_hi = ^acc[ACC_W-1:DATA_WIDTH];

    always_ff @(posedge clk) begin
        if (i_rst) begin
            state   <= IDLE;
            i       <= '0;
            j       <= '0;
            k       <= '0;
            acc     <= '0;
            rd_en_d <= 1'b0;
            first_d <= 1'b0;
        end else begin
            rd_en_d <= rd_en;
            first_d <= rd_en && (k == '0);
            // First product of an element loads rather than adds, so no clear cycle.
            if (rd_en_d)
                acc <= first_d ? ACC_W'(prod) : acc + ACC_W'(prod);

            case (state)
                IDLE: begin
                    if (i_start) begin
                        i     <= '0;
                        j     <= '0;
                        k     <= '0;
                        acc   <= '0;
                        state <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (k == KW'(K - 1))
                        state <= DRAIN;
                    else
                        k <= k + 1'b1;
                end
                DRAIN: state <= WRITE;
                WRITE: begin
                    k <= '0;
                    if (j == JW'(W - 1)) begin
                        j <= '0;
                        if (i == IW'(H - 1)) begin
                            state <= DONE;
                        end else begin
                            i     <= i + 1'b1;
                            state <= ISSUE;
                        end
                    end else begin
                        j     <= j + 1'b1;
                        state <= ISSUE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_matrix_mult_scheduler.sv
// Directed bench: a 2x2x2 scheduler and a default 5x5x5 scheduler, each with
// registered A/B memory models and hand-computed expected results.
module tb_matrix_mult_scheduler;
    logic clk = 1'b0;
    logic rst;
    logic start_b, start_s;
    logic busy_b, done_b, busy_s, done_s;
    int   n_checks = 0;
    int   n_fail   = 0;

    logic [7:0] a_big [0:255];
    logic [7:0] b_big [0:255];
    logic [7:0] exp_big [0:24];
    logic [7:0] a_sm [0:255];
    logic [7:0] b_sm [0:255];
    logic [7:0] exp_sm [0:3];

    matrix_mult_scheduler_if #(.DATA_WIDTH(8), .ADDR_WIDTH(8)) mem_b ();
    matrix_mult_scheduler_if #(.DATA_WIDTH(8), .ADDR_WIDTH(8)) mem_s ();

    matrix_mult_scheduler dut_big (
        .clk     (clk),
        .i_rst   (rst),
        .i_start (start_b),
        .o_busy  (busy_b),
        .o_done  (done_b),
        .mem     (mem_b)
    );

    matrix_mult_scheduler #(
        .FIRST_MATRIX_HEIGHT (2),
        .BOTH_MATRIX_W_H     (2),
        .SECOND_MATRIX_WIDTH (2),
        .DATA_WIDTH          (8),
        .ADDR_WIDTH          (8)
    ) dut_small (
        .clk     (clk),
        .i_rst   (rst),
        .i_start (start_s),
        .o_busy  (busy_s),
        .o_done  (done_s),
        .mem     (mem_s)
    );

    always #5 clk = ~clk;

    // Operand memories: data appears the cycle after the read strobe.
    always @(posedge clk) begin
        mem_b.i_a_data <= mem_b.o_rd_en ? a_big[mem_b.o_a_addr] : 8'h00;
        mem_b.i_b_data <= mem_b.o_rd_en ? b_big[mem_b.o_b_addr] : 8'h00;
        mem_s.i_a_data <= mem_s.o_rd_en ? a_sm[mem_s.o_a_addr] : 8'h00;
        mem_s.i_b_data <= mem_s.o_rd_en ? b_sm[mem_s.o_b_addr] : 8'h00;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic fill_const(input logic [7:0] v, input logic [7:0] res);
        for (int e = 0; e < 25; e++) begin
            a_big[e]   = v;
            b_big[e]   = v;
            exp_big[e] = res;
        end
    endtask

    task automatic fill_model();
        int sum;
        for (int e = 0; e < 25; e++) begin
            a_big[e] = 8'(e + 1);
            b_big[e] = 8'((3 * e + 7) % 32);
        end
        for (int r = 0; r < 5; r++)
            for (int c = 0; c < 5; c++) begin
                sum = 0;
                for (int q = 0; q < 5; q++)
                    sum += int'(a_big[r*5+q]) * int'(b_big[q*5+c]);
                exp_big[r*5+c] = 8'(sum);
            end
    endtask

    // Runs the 5x5x5 scheduler from a start pulse; cycle 1 is the first cycle after the start edge.
    task automatic run_job(input string tag, input int rst_cycle, input bit hold, input int n_runs,
                           input int exp_wr, input int exp_rd, input int exp_done, input bit detail);
        int cyc, wr_idx, rd_cnt, done_cnt, limit, e;
        limit    = (rst_cycle > 0) ? rst_cycle + 6 : n_runs * 177 + 4;
        wr_idx   = 0;
        rd_cnt   = 0;
        done_cnt = 0;
        start_b  = 1'b1;
        step();
        cyc = 1;
        while (cyc <= limit) begin
            if (mem_b.o_rd_en) rd_cnt++;
            if (mem_b.o_wr_en) begin
                e = wr_idx % 25;
                check({tag, "_wr_addr"}, 64'(mem_b.o_wr_addr), 64'(e));
                check({tag, "_wr_data"}, 64'(mem_b.o_wr_data), 64'(exp_big[e]));
                check({tag, "_wr_cycle"}, 64'(cyc), 64'((wr_idx / 25) * 177 + (e + 1) * 7));
                check({tag, "_wr_rd_excl"}, 64'(mem_b.o_rd_en), 64'(0));
                wr_idx++;
            end
            if (done_b) begin
                check({tag, "_done_cycle"}, 64'(cyc), 64'(done_cnt * 177 + 176));
                check({tag, "_busy_in_done"}, 64'(busy_b), 64'(0));
                done_cnt++;
            end
            if (detail) begin
                case (cyc)
                    1: check({tag, "_c1"}, 64'({busy_b, mem_b.o_rd_en, mem_b.o_a_addr, mem_b.o_b_addr}),
                             64'({1'b1, 1'b1, 8'd0, 8'd0}));
                    2: check({tag, "_c2_addr"}, 64'({mem_b.o_a_addr, mem_b.o_b_addr}), 64'({8'd1, 8'd5}));
                    6: check({tag, "_drain_zero"}, 64'({mem_b.o_rd_en, mem_b.o_wr_en, mem_b.o_a_addr,
                             mem_b.o_b_addr, mem_b.o_wr_addr, mem_b.o_wr_data}), 64'(0));
                    9: check({tag, "_c9_addr"}, 64'({mem_b.o_a_addr, mem_b.o_b_addr}), 64'({8'd1, 8'd6}));
                    173: check({tag, "_c173_addr"}, 64'({mem_b.o_a_addr, mem_b.o_b_addr}),
                               64'({8'd24, 8'd24}));
                    175: check({tag, "_c175_busy"}, 64'(busy_b), 64'(1));
                    default: ;
                endcase
            end
            if (cyc == rst_cycle + 1)
                check({tag, "_rst_outs"}, 64'({busy_b, done_b, mem_b.o_rd_en, mem_b.o_wr_en, mem_b.o_a_addr,
                      mem_b.o_b_addr, mem_b.o_wr_addr, mem_b.o_wr_data}), 64'(0));
            if (hold && cyc == 177)
                check({tag, "_idle_gap"}, 64'({busy_b, done_b, mem_b.o_rd_en}), 64'(0));
            if (hold && cyc == 178)
                check({tag, "_restart"}, 64'({busy_b, mem_b.o_rd_en, mem_b.o_a_addr}),
                      64'({1'b1, 1'b1, 8'd0}));
            start_b = (hold && cyc < n_runs * 177) || (detail && (cyc == 10 || cyc == 176));
            rst     = (cyc == rst_cycle);
            step();
            cyc++;
        end
        start_b = 1'b0;
        rst     = 1'b0;
        check({tag, "_n_writes"}, 64'(wr_idx), 64'(exp_wr));
        check({tag, "_n_reads"}, 64'(rd_cnt), 64'(exp_rd));
        check({tag, "_n_done"}, 64'(done_cnt), 64'(exp_done));
    endtask

    initial begin
        int wr_idx, done_cnt;
        for (int e = 0; e < 256; e++) begin
            a_big[e] = 8'h00;
            b_big[e] = 8'h00;
            a_sm[e]  = 8'h00;
            b_sm[e]  = 8'h00;
        end
        rst     = 1'b1;
        start_b = 1'b0;
        start_s = 1'b0;
        step();
        step();
        check("reset_big", 64'({busy_b, done_b, mem_b.o_rd_en, mem_b.o_wr_en, mem_b.o_a_addr,
              mem_b.o_b_addr, mem_b.o_wr_addr, mem_b.o_wr_data}), 64'(0));
        check("reset_small", 64'({busy_s, done_s, mem_s.o_rd_en, mem_s.o_wr_en, mem_s.o_wr_addr,
              mem_s.o_wr_data}), 64'(0));
        rst = 1'b0;
        step();

        // 2x2: A = [[1,2],[3,4]], B = identity
        a_sm[0] = 8'd1; a_sm[1] = 8'd2; a_sm[2] = 8'd3; a_sm[3] = 8'd4;
        b_sm[0] = 8'd1; b_sm[1] = 8'd0; b_sm[2] = 8'd0; b_sm[3] = 8'd1;
        exp_sm[0] = 8'd1; exp_sm[1] = 8'd2; exp_sm[2] = 8'd3; exp_sm[3] = 8'd4;
        wr_idx   = 0;
        done_cnt = 0;
        start_s  = 1'b1;
        step();
        start_s = 1'b0;
        for (int cyc = 1; cyc <= 20; cyc++) begin
            if (mem_s.o_wr_en) begin
                if (wr_idx < 4) begin
                    check("sm_wr_addr", 64'(mem_s.o_wr_addr), 64'(wr_idx));
                    check("sm_wr_data", 64'(mem_s.o_wr_data), 64'(exp_sm[wr_idx]));
                    check("sm_wr_cycle", 64'(cyc), 64'((wr_idx + 1) * 4));
                end
                wr_idx++;
            end
            if (done_s) begin
                check("sm_done_cycle", 64'(cyc), 64'(17));
                done_cnt++;
            end
            step();
        end
        check("sm_n_writes", 64'(wr_idx), 64'(4));
        check("sm_n_done", 64'(done_cnt), 64'(1));

        fill_const(8'd1, 8'd5);
        run_job("ones", -1, 1'b0, 1, 25, 125, 1, 1'b1);
        fill_const(8'd16, 8'h00);
        run_job("sixteen", -1, 1'b0, 1, 25, 125, 1, 1'b0);
        fill_const(8'd15, 8'h65);
        run_job("fifteen", -1, 1'b0, 1, 25, 125, 1, 1'b0);
        fill_model();
        run_job("mid_reset", 40, 1'b0, 1, 5, 30, 0, 1'b0);
        run_job("after_reset", -1, 1'b0, 1, 25, 125, 1, 1'b0);
        fill_const(8'd1, 8'd5);
        run_job("held_start", -1, 1'b1, 2, 50, 250, 2, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
